// File: rtl/hpu_cmd_id_tracker_pkg.sv
// Shared configuration and types for the HPU command-id tracker.
// Holds the command-id layout carried on completion responses
// and the slot-id type shared by the allocator and the slot banks.
package hpu_cmd_id_tracker_pkg;

   localparam int NUM_CORES          = 8;
   localparam int NUM_HPU_CMDS       = 4;
   localparam int NUM_CLUSTERS       = 4;
   localparam int NUM_CMD_INTERFACES = 3;

   localparam int CLUSTER_W = $clog2(NUM_CLUSTERS);
   localparam int CORE_W    = $clog2(NUM_CORES);
   localparam int SLOT_W    = $clog2(NUM_HPU_CMDS);

   typedef logic [SLOT_W-1:0] hpu_slot_id_t;

   // Globally unique command id: which cluster, which core, which local slot.
   typedef struct packed {
      logic [CLUSTER_W-1:0] cluster_id;
      logic [CORE_W-1:0]    core_id;
      hpu_slot_id_t         local_cmd_id;
   } pspin_cmd_id_t;

endpackage

// File: rtl/hpu_cmd_id_tracker_if.sv
// Bundle between the HPU drivers / command unit and the id tracker.
// master = driver/command-unit side, slave = tracker side.
// Responses carry no backpressure; allocation is request/grant.
interface hpu_cmd_id_tracker_if
   import hpu_cmd_id_tracker_pkg::*;
#(
   parameter int NUM_CORES      = hpu_cmd_id_tracker_pkg::NUM_CORES,
   parameter int NUM_HPU_CMDS   = hpu_cmd_id_tracker_pkg::NUM_HPU_CMDS,
   parameter int NUM_CLUSTERS   = hpu_cmd_id_tracker_pkg::NUM_CLUSTERS,
   parameter int NUM_RESP_PORTS = hpu_cmd_id_tracker_pkg::NUM_CMD_INTERFACES
);
   localparam int CW = $clog2(NUM_CLUSTERS);
   localparam int SW = $clog2(NUM_HPU_CMDS);
   localparam int KW = $clog2(NUM_CORES);

   logic [CW-1:0]                        cluster_id_i;
   logic [NUM_CORES-1:0]                 alloc_req_i;
   logic [NUM_CORES-1:0]                 alloc_evt_i;
   logic [NUM_CORES-1:0]                 alloc_gnt_o;
   hpu_slot_id_t [NUM_CORES-1:0]         alloc_id_o;
   logic [NUM_RESP_PORTS-1:0]            resp_valid_i;
   pspin_cmd_id_t [NUM_RESP_PORTS-1:0]   resp_cmd_id_i;
   logic [KW-1:0]                        test_core_i;
   hpu_slot_id_t                         test_id_i;
   logic                                 test_done_o;
   logic [NUM_CORES-1:0][SW:0]           inflight_cnt_o;
   logic [NUM_CORES-1:0]                 evt_valid_o;
   hpu_slot_id_t [NUM_CORES-1:0]         evt_id_o;
   logic                                 spurious_o;

   modport master (
      output cluster_id_i, alloc_req_i, alloc_evt_i, resp_valid_i, resp_cmd_id_i,
             test_core_i, test_id_i,
      input  alloc_gnt_o, alloc_id_o, test_done_o, inflight_cnt_o,
             evt_valid_o, evt_id_o, spurious_o
   );

   modport slave (
      input  cluster_id_i, alloc_req_i, alloc_evt_i, resp_valid_i, resp_cmd_id_i,
             test_core_i, test_id_i,
      output alloc_gnt_o, alloc_id_o, test_done_o, inflight_cnt_o,
             evt_valid_o, evt_id_o, spurious_o
   );

endinterface

// File: rtl/hpu_cmd_slot_bank.sv
// Per-core slot state: busy/evt/pending bitmaps, free-slot pick, in-flight count, event drain.
// Latency: grant is combinational from registers; retire and event pulse appear one edge later.
// Backpressure: none; queued events drain one per cycle, lowest slot first.
module hpu_cmd_slot_bank
   import hpu_cmd_id_tracker_pkg::*;
#(
   parameter int NUM_HPU_CMDS   = hpu_cmd_id_tracker_pkg::NUM_HPU_CMDS,
   parameter int NUM_RESP_PORTS = hpu_cmd_id_tracker_pkg::NUM_CMD_INTERFACES,
   localparam int SW            = $clog2(NUM_HPU_CMDS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              alloc_req,
   input  logic                              alloc_evt,
   output logic                              alloc_gnt,
   output hpu_slot_id_t                      alloc_id,
   input  logic [NUM_RESP_PORTS-1:0]         ret_vld,
   input  hpu_slot_id_t [NUM_RESP_PORTS-1:0] ret_slot,
   output logic [NUM_HPU_CMDS-1:0]           busy,
   output logic [SW:0]                       inflight_cnt,
   output logic                              evt_valid,
   output hpu_slot_id_t                      evt_id
);

   logic [NUM_HPU_CMDS-1:0] evt_bm;
   logic [NUM_HPU_CMDS-1:0] pending;

   logic [NUM_HPU_CMDS-1:0] clr_mask;
   logic [NUM_HPU_CMDS-1:0] set_mask;
   logic [NUM_HPU_CMDS-1:0] new_evt;
   logic [NUM_HPU_CMDS-1:0] pending_nxt;
   logic [SW:0]             retire_cnt;
   logic                    first_vld;
   hpu_slot_id_t            first_slot;
   hpu_slot_id_t            pend_low;
   logic                    evt_valid_nxt;
   hpu_slot_id_t            evt_id_nxt;

   // Lowest free slot from the registered bitmap; grant only when not full.
   always_comb begin
      alloc_id = '0;
      for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
         if (!busy[i]) alloc_id = hpu_slot_id_t'(i);
      end
      alloc_gnt = alloc_req & ~(&busy);
      set_mask  = '0;
      for (int i = 0; i < NUM_HPU_CMDS; i++) begin
         set_mask[i] = alloc_gnt && (alloc_id == hpu_slot_id_t'(i));
      end
   end

   // Retire mask, retirement count and the first event in port order.
   always_comb begin
      clr_mask   = '0;
      first_vld  = 1'b0;
      first_slot = '0;
      for (int p = 0; p < NUM_RESP_PORTS; p++) begin
         if (ret_vld[p]) clr_mask[ret_slot[p]] = 1'b1;
      end
      // Descending scan so the lowest port with an event wins.
      for (int p = NUM_RESP_PORTS - 1; p >= 0; p--) begin
         if (ret_vld[p] && evt_bm[ret_slot[p]]) begin
            first_vld  = 1'b1;
            first_slot = ret_slot[p];
         end
      end
      retire_cnt = '0;
      for (int i = 0; i < NUM_HPU_CMDS; i++) begin
         retire_cnt = retire_cnt + {{SW{1'b0}}, clr_mask[i]};
      end
      new_evt = clr_mask & evt_bm;
   end

   // Event selection: older queued events drain before newly arrived ones.
   always_comb begin
      pend_low = '0;
      for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
         if (pending[i]) pend_low = hpu_slot_id_t'(i);
      end
      evt_valid_nxt = 1'b0;
      evt_id_nxt    = '0;
      pending_nxt   = new_evt;
      if (|pending) begin
         evt_valid_nxt = 1'b1;
         evt_id_nxt    = pend_low;
         pending_nxt   = pending | new_evt;
         pending_nxt[pend_low] = 1'b0;
      end else if (first_vld) begin
         evt_valid_nxt = 1'b1;
         evt_id_nxt    = first_slot;
         pending_nxt[first_slot] = 1'b0;
      end
   end

   // Bitmaps, counter and event outputs update together on each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy         <= '0;
         evt_bm       <= '0;
         pending      <= '0;
         inflight_cnt <= '0;
         evt_valid    <= 1'b0;
         evt_id       <= '0;
      end else begin
         busy         <= (busy & ~clr_mask) | set_mask;
         evt_bm       <= (evt_bm & ~clr_mask) | (set_mask & {NUM_HPU_CMDS{alloc_evt}});
         pending      <= pending_nxt;
         inflight_cnt <= inflight_cnt + {{SW{1'b0}}, alloc_gnt} - retire_cnt;
         evt_valid    <= evt_valid_nxt;
         evt_id       <= evt_id_nxt;
      end
   end

endmodule

// File: rtl/hpu_cmd_id_tracker.sv
// Cluster-level HPU command-id allocator/retire tracker with per-core completion events.
// Latency: grant 0 cycles, slot free and event pulse 1 cycle after the response.
// Backpressure: none on responses; bad responses are dropped and flagged on sticky spurious_o.
module hpu_cmd_id_tracker
   import hpu_cmd_id_tracker_pkg::*;
#(
   parameter int NUM_CORES      = hpu_cmd_id_tracker_pkg::NUM_CORES,
   parameter int NUM_HPU_CMDS   = hpu_cmd_id_tracker_pkg::NUM_HPU_CMDS,
   parameter int NUM_CLUSTERS   = hpu_cmd_id_tracker_pkg::NUM_CLUSTERS,
   parameter int NUM_RESP_PORTS = hpu_cmd_id_tracker_pkg::NUM_CMD_INTERFACES
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   hpu_cmd_id_tracker_if.slave  bus
);
   localparam int SW = $clog2(NUM_HPU_CMDS);

   logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0]   busy;
   logic [NUM_CORES-1:0][NUM_RESP_PORTS-1:0] ret_vld;
   hpu_slot_id_t [NUM_RESP_PORTS-1:0]        ret_slot;
   logic [NUM_RESP_PORTS-1:0]                match;
   logic [NUM_RESP_PORTS-1:0]                dup;
   logic [NUM_RESP_PORTS-1:0]                retire;
   logic [NUM_RESP_PORTS-1:0]                bad;
   logic                                     spurious;

   logic [NUM_CORES-1:0]                     gnt;
   hpu_slot_id_t [NUM_CORES-1:0]             alloc_id;
   logic [NUM_CORES-1:0][SW:0]               cnt;
   logic [NUM_CORES-1:0]                     evt_valid;
   hpu_slot_id_t [NUM_CORES-1:0]             evt_id;

   // Response decode: cluster match, duplicate suppression, busy check, per-core routing.
   always_comb begin
      match   = '0;
      dup     = '0;
      retire  = '0;
      bad     = '0;
      ret_vld = '0;
      for (int p = 0; p < NUM_RESP_PORTS; p++) begin
         ret_slot[p] = bus.resp_cmd_id_i[p].local_cmd_id;
         match[p]    = bus.resp_valid_i[p] &&
                       (bus.resp_cmd_id_i[p].cluster_id == bus.cluster_id_i);
      end
      for (int p = 0; p < NUM_RESP_PORTS; p++) begin
         // A later port naming a slot already named by an earlier port is a duplicate.
         for (int q = 0; q < NUM_RESP_PORTS; q++) begin
            if (q < p && match[q] &&
                bus.resp_cmd_id_i[q].core_id == bus.resp_cmd_id_i[p].core_id &&
                bus.resp_cmd_id_i[q].local_cmd_id == bus.resp_cmd_id_i[p].local_cmd_id)
               dup[p] = 1'b1;
         end
         retire[p] = match[p] && !dup[p] &&
                     busy[bus.resp_cmd_id_i[p].core_id][bus.resp_cmd_id_i[p].local_cmd_id];
         bad[p]    = bus.resp_valid_i[p] && !retire[p];
         for (int c = 0; c < NUM_CORES; c++) begin
            ret_vld[c][p] = retire[p] && (bus.resp_cmd_id_i[p].core_id == CORE_W'(c));
         end
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) spurious <= 1'b0;
      else if (|bad) spurious <= 1'b1;
   end

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      hpu_cmd_slot_bank #(
         .NUM_HPU_CMDS   (NUM_HPU_CMDS),
         .NUM_RESP_PORTS (NUM_RESP_PORTS)
      ) u_bank (
         .clk          (clk_i),
         .rst_n        (rst_ni),
         .alloc_req    (bus.alloc_req_i[c]),
         .alloc_evt    (bus.alloc_evt_i[c]),
         .alloc_gnt    (gnt[c]),
         .alloc_id     (alloc_id[c]),
         .ret_vld      (ret_vld[c]),
         .ret_slot     (ret_slot),
         .busy         (busy[c]),
         .inflight_cnt (cnt[c]),
         .evt_valid    (evt_valid[c]),
         .evt_id       (evt_id[c])
      );
   end

   assign bus.alloc_gnt_o    = gnt;
   assign bus.alloc_id_o     = alloc_id;
   assign bus.inflight_cnt_o = cnt;
   assign bus.evt_valid_o    = evt_valid;
   assign bus.evt_id_o       = evt_id;
   assign bus.spurious_o     = spurious;
   assign bus.test_done_o    = ~busy[bus.test_core_i][bus.test_id_i];

endmodule

// File: tb/tb_hpu_cmd_id_tracker.sv
// Directed bench for hpu_cmd_id_tracker: allocation, retirement, events, spurious and reset.
// Inputs change 1 ns after the rising edge; outputs are checked in the same window.
// Expected values are hand-derived constants for each step.
module tb_hpu_cmd_id_tracker;
   import hpu_cmd_id_tracker_pkg::*;

   localparam int CL = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   hpu_cmd_id_tracker_if bus ();

   hpu_cmd_id_tracker dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.alloc_req_i   = '0;
      bus.alloc_evt_i   = '0;
      bus.resp_valid_i  = '0;
      bus.resp_cmd_id_i = '0;
   endtask

   task automatic resp(input int port, input int cl, input int core, input int slot);
      pspin_cmd_id_t r;
      r.cluster_id   = CLUSTER_W'(cl);
      r.core_id      = CORE_W'(core);
      r.local_cmd_id = SLOT_W'(slot);
      bus.resp_valid_i[port]  = 1'b1;
      bus.resp_cmd_id_i[port] = r;
   endtask

   initial begin
      bus.cluster_id_i = CLUSTER_W'(CL);
      bus.test_core_i  = '0;
      bus.test_id_i    = 2'd2;
      idle();
      #12;
      // Reset state
      chk("rst_gnt", bus.alloc_gnt_o, 0);
      chk("rst_cnt", bus.inflight_cnt_o, 0);
      chk("rst_evt", bus.evt_valid_o, 0);
      chk("rst_spur", bus.spurious_o, 0);
      chk("rst_tdone", bus.test_done_o, 1);
      rst_n = 1'b1;

      // Core 0: four grants 0..3, fifth refused
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.alloc_req_i[0] = 1'b1;
         #1;
         chk("c0_gnt", bus.alloc_gnt_o[0], 1);
         chk("c0_id", bus.alloc_id_o[0], i);
      end
      tick();
      chk("c0_full_gnt", bus.alloc_gnt_o[0], 0);
      chk("c0_cnt", bus.inflight_cnt_o[0], 4);
      chk("c0_tdone", bus.test_done_o, 0);
      idle();

      // Core 2: fill with evt on slot 1, retire slot 1 on port 0
      for (int i = 0; i < 4; i++) begin
         tick(); idle();
         bus.alloc_req_i[2] = 1'b1;
         bus.alloc_evt_i[2] = (i == 1);
      end
      tick(); idle();
      chk("c2_cnt4", bus.inflight_cnt_o[2], 4);
      resp(0, CL, 2, 1);
      tick(); idle();
      chk("c2_evt_vld", bus.evt_valid_o, 8'h04);
      chk("c2_evt_id", bus.evt_id_o[2], 1);
      chk("c2_cnt3", bus.inflight_cnt_o[2], 3);
      tick();
      chk("c2_evt_off", bus.evt_valid_o, 0);
      bus.alloc_req_i[2] = 1'b1;
      #1;
      chk("c2_regnt", bus.alloc_gnt_o[2], 1);
      chk("c2_reid", bus.alloc_id_o[2], 1);
      tick(); idle();
      chk("c2_cnt4b", bus.inflight_cnt_o[2], 4);

      // Core 5: slots 0,2 busy with evt; two events in one cycle
      for (int i = 0; i < 3; i++) begin
         tick(); idle();
         bus.alloc_req_i[5] = 1'b1;
         bus.alloc_evt_i[5] = (i != 1);
      end
      tick(); idle();
      resp(1, CL, 5, 1);
      tick(); idle();
      chk("c5_noevt", bus.evt_valid_o, 0);
      chk("c5_cnt2", bus.inflight_cnt_o[5], 2);
      resp(0, CL, 5, 0);
      resp(2, CL, 5, 2);
      tick(); idle();
      chk("c5_evt1_vld", bus.evt_valid_o, 8'h20);
      chk("c5_evt1_id", bus.evt_id_o[5], 0);
      chk("c5_cnt0", bus.inflight_cnt_o[5], 0);
      tick();
      chk("c5_evt2_vld", bus.evt_valid_o, 8'h20);
      chk("c5_evt2_id", bus.evt_id_o[5], 2);
      tick();
      chk("c5_evt_off", bus.evt_valid_o, 0);

      // Core 5: port order beats slot order for the first event
      for (int i = 0; i < 2; i++) begin
         tick(); idle();
         bus.alloc_req_i[5] = 1'b1;
         bus.alloc_evt_i[5] = 1'b1;
      end
      tick(); idle();
      resp(0, CL, 5, 1);
      resp(1, CL, 5, 0);
      tick(); idle();
      chk("c5_ord1_vld", bus.evt_valid_o, 8'h20);
      chk("c5_ord1_id", bus.evt_id_o[5], 1);
      tick();
      chk("c5_ord2_vld", bus.evt_valid_o, 8'h20);
      chk("c5_ord2_id", bus.evt_id_o[5], 0);
      tick();
      chk("c5_ord_off", bus.evt_valid_o, 0);

      // Spurious: foreign cluster, then idle slot
      chk("spur_pre", bus.spurious_o, 0);
      bus.test_id_i = 2'd0;
      resp(1, CL + 1, 0, 0);
      tick(); idle();
      chk("spur_cl", bus.spurious_o, 1);
      chk("spur_cl_cnt", bus.inflight_cnt_o[0], 4);
      chk("spur_cl_busy", bus.test_done_o, 0);
      resp(0, CL, 5, 3);
      tick(); idle();
      chk("spur_idle", bus.spurious_o, 1);
      chk("spur_idle_cnt", bus.inflight_cnt_o[5], 0);

      // Core 1 full: retire slot 3 and request in the same cycle
      for (int i = 0; i < 4; i++) begin
         tick(); idle();
         bus.alloc_req_i[1] = 1'b1;
      end
      tick(); idle();
      chk("c1_cnt4", bus.inflight_cnt_o[1], 4);
      resp(0, CL, 1, 3);
      bus.alloc_req_i[1] = 1'b1;
      #1;
      chk("c1_nognt", bus.alloc_gnt_o[1], 0);
      tick();
      bus.resp_valid_i = '0;
      #1;
      chk("c1_cnt3", bus.inflight_cnt_o[1], 3);
      chk("c1_gnt", bus.alloc_gnt_o[1], 1);
      chk("c1_id", bus.alloc_id_o[1], 3);
      tick(); idle();
      chk("c1_cnt4b", bus.inflight_cnt_o[1], 4);

      // Reset mid-run
      tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_cnt", bus.inflight_cnt_o, 0);
      chk("mrst_evt", bus.evt_valid_o, 0);
      chk("mrst_gnt", bus.alloc_gnt_o, 0);
      chk("mrst_id", bus.alloc_id_o, 0);
      chk("mrst_spur", bus.spurious_o, 0);
      chk("mrst_tdone", bus.test_done_o, 1);
      #3;
      rst_n = 1'b1;
      tick();
      resp(0, CL, 0, 0);
      tick(); idle();
      chk("late_spur", bus.spurious_o, 1);

      // Duplicate slot on two ports: first retires, second is spurious
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick(); idle();
      bus.alloc_req_i[3] = 1'b1;
      tick(); idle();
      chk("dup_pre_spur", bus.spurious_o, 0);
      chk("dup_pre_cnt", bus.inflight_cnt_o[3], 1);
      resp(0, CL, 3, 0);
      resp(1, CL, 3, 0);
      tick(); idle();
      chk("dup_cnt", bus.inflight_cnt_o[3], 0);
      chk("dup_spur", bus.spurious_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
